seg_display_conditioner: RTL

//  Sits directly downstream of a 7-segment output PIO in the alarm-clock SoC; consumes its raw segment pattern and drives the HEX pins.

---
 rtl/seg_display_conditioner_pkg.sv | 26 ++
 rtl/seg_display_conditioner_if.sv | 11 +
 rtl/seg_display_conditioner_blink.sv | 32 +++
 rtl/seg_display_conditioner.sv | 87 ++++++++
 4 files changed

// File: rtl/seg_display_conditioner_pkg.sv
// Shared constants for the 7-segment display conditioner: register map,
// CTRL bit layout and the blank/lamp drive patterns.
package seg_disp_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_HALF   = 2'd1;
  localparam logic [1:0] ADDR_DUTY   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_BLINK = 0;
  localparam int CTRL_PWM   = 1;
  localparam int CTRL_BLANK = 2;
  localparam int CTRL_LAMP  = 3;

  // Wide enough for any SEG_W; callers slice to their width.
  localparam logic [31:0] PAT_LAMP  = '1;
  localparam logic [31:0] PAT_BLANK = '0;

  typedef struct packed {
    logic lamp_test;
    logic force_blank;
    logic pwm_en;
    logic blink_en;
  } ctrl_t;

endpackage

// File: rtl/seg_display_conditioner_if.sv
// Avalon-MM slave port of the display conditioner (4-word register window).
interface seg_disp_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/seg_display_conditioner_blink.sv
// Blink half-period timer: div_cnt runs 0..half_period-1 and toggles phase
// at terminal count; frozen visible while disabled or half_period==0.
module seg_blink_timer #(
  parameter int DIV_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] half_period,
  output logic             phase
);

  logic [DIV_W-1:0] div_cnt;
  logic             term;

  assign term = (div_cnt == half_period - DIV_W'(1));

  // load outranks terminal count so a reconfigure never swallows a fresh half-period
  always_ff @(posedge clk) begin
    if (reset || load || !en || half_period == '0) begin
      div_cnt <= '0;
      phase   <= 1'b1;
    end else if (term) begin
      div_cnt <= '0;
      phase   <= ~phase;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/seg_display_conditioner.sv
// Conditions the raw segment PIO pattern for the HEX pins: blink, PWM dimming,
// blank and lamp-test, configured over a small Avalon-MM register window.
module seg_display_conditioner
  import seg_disp_pkg::*;
#(
  parameter int SEG_W      = 7,
  parameter int DIV_W      = 26,
  parameter int PWM_W      = 8,
  parameter int DEF_HALF   = 25_000_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEG_W-1:0] seg_in,
  seg_disp_if.slave        bus,
  output logic [SEG_W-1:0] hex_out
);

  ctrl_t            ctrl;
  logic [DIV_W-1:0] half;
  logic [PWM_W-1:0] duty;
  logic [PWM_W-1:0] pwm_cnt;
  logic             wr, blink_load, phase, pwm_on;
  logic [SEG_W-1:0] vis;
  logic             unused_wdata;

  assign wr           = bus.chipselect & ~bus.write_n;
  assign unused_wdata = ^bus.writedata[31:DIV_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl <= '0;
      half <= DIV_W'(DEF_HALF);
      duty <= '1;
    end else if (wr) begin
      case (bus.address)
        ADDR_CTRL: ctrl <= ctrl_t'(bus.writedata[3:0]);
        ADDR_HALF: half <= bus.writedata[DIV_W-1:0];
        ADDR_DUTY: duty <= bus.writedata[PWM_W-1:0];
        default:   ;
      endcase
    end
  end

  // restart the blink from the visible phase on any reprogram of the period or on enable
  assign blink_load = wr & ((bus.address == ADDR_HALF) |
                            ((bus.address == ADDR_CTRL) & bus.writedata[CTRL_BLINK] & ~ctrl.blink_en));

  seg_blink_timer #(.DIV_W(DIV_W)) u_blink (
    .clk         (clk),
    .reset       (reset),
    .en          (ctrl.blink_en),
    .load        (blink_load),
    .half_period (half),
    .phase       (phase)
  );

  always_ff @(posedge clk) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + PWM_W'(1);
  end

  assign pwm_on = (pwm_cnt < duty) | (&duty) | ~ctrl.pwm_en;

  always_comb begin
    vis = seg_in & {SEG_W{phase & pwm_on}};
    if (ctrl.lamp_test)        vis = PAT_LAMP[SEG_W-1:0];
    else if (ctrl.force_blank) vis = PAT_BLANK[SEG_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) hex_out <= ACTIVE_LOW ? ~PAT_BLANK[SEG_W-1:0] : PAT_BLANK[SEG_W-1:0];
    else       hex_out <= ACTIVE_LOW ? ~vis : vis;
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_CTRL:   bus.readdata[3:0]       = ctrl;
      ADDR_HALF:   bus.readdata[DIV_W-1:0] = half;
      ADDR_DUTY:   bus.readdata[PWM_W-1:0] = duty;
      ADDR_STATUS: bus.readdata[1:0]       = {pwm_on, phase};
      default:     ;
    endcase
  end

endmodule
